// File: rtl/fifo_wptr_full_if.sv
// Write-side port bundle of the dual-clock FIFO: producer request, RAM write port,
// Gray pointer exchange with the read domain, and write-domain status flags.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;

  modport slave (
    input  wr_en, rptr_gray,
    output wr_accept, wr_addr, wptr_gray, full, almost_full, level, overflow
  );

  modport master (
    output wr_en, rptr_gray,
    input  wr_accept, wr_addr, wptr_gray, full, almost_full, level, overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write pointer, Gray export and full/almost-full/level/overflow for the dual-clock FIFO.
// Latency: accepted write visible after the same edge; read pointer moves seen 3 edges later.
// Backpressure: wr_accept = wr_en & ~full; writes while full are dropped and flag overflow.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input logic             clk,
  input logic             rst_n,
  fifo_wptr_full_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_TH     = PW'((1 << ADDR_WIDTH) - AF_MARGIN);
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

  logic [PW-1:0] r_rq1;
  logic [PW-1:0] r_rq2;
  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_af;
  logic          r_ovf;

  logic [PW-1:0] w_rbin;
  logic          w_push;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_level_next;
  logic          w_full_next;

  // Gray to binary: each binary bit is the running XOR of the Gray bits from the MSB down.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    w_rbin = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      acc       = acc ^ r_rq2[i];
      w_rbin[i] = acc;
    end
  end

  assign w_push       = bus.wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + PW'(w_push);
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign w_full_next  = (w_wgray_next == (r_rq2 ^ FULL_MASK));
  assign w_level_next = w_wbin_next - w_rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rq1   <= '0;
      r_rq2   <= '0;
      r_wbin  <= '0;
      r_wgray <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_rq1   <= bus.rptr_gray;
      r_rq2   <= r_rq1;
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_level <= w_level_next;
      r_full  <= w_full_next;
      r_af    <= (w_level_next >= AF_TH);
      r_ovf   <= r_ovf | (bus.wr_en & r_full);
    end
  end

  assign bus.wr_accept   = w_push;
  assign bus.wr_addr     = r_wbin[ADDR_WIDTH-1:0];
  assign bus.wptr_gray   = r_wgray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_af;
  assign bus.level       = r_level;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: occupancy-count model checked every cycle plus hand-computed pins.
module tb_fifo_wptr_full;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: total accepted writes, total reads issued, and what the writer has seen of them.
  int rd_cnt    = 0;
  int m_wcnt    = 0;
  int m_lvl     = 0;
  int m_ovf     = 0;
  int m_lastacc = 0;
  int rd_seen1  = 0;
  int rd_seen2  = 0;
  logic [AW:0] prev_g = '0;

  function automatic logic [AW:0] gray_of(int c);
    logic [AW:0] b;
    b = c[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_rd(int c);
    rd_cnt        = c;
    bus.rptr_gray = gray_of(c);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wcnt = 0; m_lvl = 0; m_ovf = 0; m_lastacc = 0;
      rd_seen1 = 0; rd_seen2 = 0;
    end else begin
      m_lastacc = (bus.wr_en && m_lvl != DEPTH) ? 1 : 0;
      if (bus.wr_en && m_lvl == DEPTH) m_ovf = 1;
      m_wcnt   = m_wcnt + m_lastacc;
      m_lvl    = m_wcnt - rd_seen2;
      rd_seen2 = rd_seen1;
      rd_seen1 = rd_cnt;
    end
  end

  always @(negedge clk) begin
    chk("wr_accept",   bus.wr_accept,   (bus.wr_en && m_lvl != DEPTH) ? 1 : 0);
    chk("wptr_gray",   bus.wptr_gray,   gray_of(m_wcnt));
    chk("wr_addr",     bus.wr_addr,     m_wcnt % DEPTH);
    chk("level",       bus.level,       m_lvl);
    chk("full",        bus.full,        (m_lvl == DEPTH) ? 1 : 0);
    chk("almost_full", bus.almost_full, (m_lvl >= DEPTH - AFM) ? 1 : 0);
    chk("overflow",    bus.overflow,    m_ovf);
    if (rst_n) chk("gray_step", $countones(bus.wptr_gray ^ prev_g), m_lastacc);
    prev_g = bus.wptr_gray;
  end

  int exp_g [4] = '{1, 3, 2, 6};

  initial begin
    bus.wr_en     = 1'b1;
    bus.rptr_gray = 5'($urandom);
    repeat (3) step();
    bus.rptr_gray = 5'($urandom);
    #1;
    chk("rst_wptr_gray", bus.wptr_gray, 0);
    chk("rst_level",     bus.level, 0);
    chk("rst_full",      bus.full, 0);
    chk("rst_overflow",  bus.overflow, 0);
    chk("rst_accept",    bus.wr_accept, 1);
    set_rd(0);
    rst_n = 1'b1;

    // Fill 16 entries with no reads.
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      if (k <= 4) chk("fill_gray", bus.wptr_gray, exp_g[k-1]);
      if (k == 13) chk("af_at_13", bus.almost_full, 0);
      if (k == 14) chk("af_at_14", bus.almost_full, 1);
      if (k == 15) chk("full_at_15", bus.full, 0);
    end
    chk("full_at_16",  bus.full, 1);
    chk("level_at_16", bus.level, 16);
    chk("gray_at_16",  bus.wptr_gray, 5'b11000);
    chk("addr_at_16",  bus.wr_addr, 0);
    #1;
    chk("accept_when_full", bus.wr_accept, 0);
    step();
    chk("gray_hold", bus.wptr_gray, 5'b11000);
    chk("ovf_set",   bus.overflow, 1);

    // One read becomes visible on the third edge.
    bus.wr_en = 1'b0;
    set_rd(1);
    step();
    chk("drain_e1_full", bus.full, 1);
    chk("drain_e1_lvl",  bus.level, 16);
    step();
    chk("drain_e2_full", bus.full, 1);
    chk("drain_e2_lvl",  bus.level, 16);
    step();
    chk("drain_e3_full", bus.full, 0);
    chk("drain_e3_lvl",  bus.level, 15);

    // Wrap: keep writing while reads trail behind.
    for (int i = 0; i < 40; i++) begin
      bus.wr_en = 1'b1;
      if (rd_cnt < m_wcnt) set_rd(rd_cnt + 1);
      step();
    end
    chk("wrapped_past_32", (m_wcnt > 32) ? 1 : 0, 1);

    // Refill to full, overrun once, then drain to empty.
    bus.wr_en = 1'b1;
    for (int i = 0; i < 40 && m_lvl != DEPTH; i++) step();
    chk("refill_full", bus.full, 1);
    step();
    bus.wr_en = 1'b0;
    set_rd(m_wcnt);
    repeat (4) step();
    chk("empty_level",  bus.level, 0);
    chk("empty_full",   bus.full, 0);
    chk("empty_af",     bus.almost_full, 0);
    chk("ovf_sticky",   bus.overflow, 1);

    // Asynchronous reset between edges during a burst.
    bus.wr_en = 1'b1;
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    set_rd(0);
    #1;
    chk("arst_gray",  bus.wptr_gray, 0);
    chk("arst_addr",  bus.wr_addr, 0);
    chk("arst_level", bus.level, 0);
    chk("arst_ovf",   bus.overflow, 0);
    chk("arst_af",    bus.almost_full, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_gray",  bus.wptr_gray, 1);
    chk("post_rst_addr",  bus.wr_addr, 1);
    chk("post_rst_level", bus.level, 1);
    bus.wr_en = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
